imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the instruction-memory read path.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each completed word into instruction memory at sequential word-aligned byte addresses, starting at 0.
- Sits between a byte source (UART receiver or debug shim) and the instruction-memory write port, so the memory can be loaded before the pipeline fetches from it.

Parameters:
- DEPTH, 16, number of 32-bit words in instruction memory; power of two, ≥2.
- ADDR_W, $clog2(DEPTH), width of the word index.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session; sampled only in IDLE or DONE.
- num_words  input  ADDR_W+1  words to load, sampled on start; 0 or >DEPTH is treated as DEPTH.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address {zeros, word_idx, 2'b00}.
- imem_wdata  output  32  assembled word.
- busy  output  1  session in progress.
- done  output  1  sticky session-complete flag.
- words_written  output  ADDR_W+1  count of words written in the current or last session.

Behaviour:
- Reset clears all state:
  - State = IDLE; byte_ready, imem_we, busy and done = 0.
  - imem_addr, imem_wdata and words_written = 0.
  - Byte lane counter = 0; target = 0.
- FSM states and transitions:
  - IDLE: byte_ready=0. start → LOAD; target latched from clamped num_words; word_idx, lane and words_written cleared; done cleared.
  - LOAD: byte_ready=1, busy=1. A transfer occurs when byte_valid && byte_ready; the byte is stored in lane `lane` (lane 0 = bits 7:0). lane increments mod 4. A transfer on lane 3 → WRITE.
  - WRITE: byte_ready=0, busy=1, imem_we=1 for exactly one cycle, with imem_addr = word_idx*4 and imem_wdata = assembled word. Next cycle: word_idx+1 and words_written+1. If words_written+1 == target → DONE, else → LOAD.
  - DONE: busy=0, done=1, byte_ready=0. start → LOAD as in IDLE, and done drops on the cycle LOAD is entered.
- Latency: 4th byte accepted at edge N → imem_we high during cycle N+1 → byte_ready high again in cycle N+2 (if words remain).
- imem_we is registered; imem_addr and imem_wdata are stable for the whole cycle imem_we is high. Outside WRITE, their values are don't-care but must not toggle imem_we.
- No backpressure from memory; the write always completes in one cycle.
- Boundaries:
  - start while busy: ignored.
  - byte_valid while not in LOAD: ignored; byte not consumed.
  - byte_valid gaps mid-word: lane holds; partial word retained indefinitely.
  - num_words=DEPTH: word_idx reaches DEPTH-1 on the last write; no wrap write ever occurs.
  - Reset mid-session (any state, including the WRITE cycle): the next cycle is IDLE with all outputs at reset values. A partial word is discarded. Words already written stay in memory.
  - start and reset in the same cycle: reset wins.
- words_written remains valid in DONE until the next start.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, WRITE, DONE as a 2-bit localparam set), and the word-to-byte-address shift constant (2) shared with the fetch-side PC mapping.
- Sub-module byte_packer (lane counter plus 4×8 shift/assemble register with a word_full pulse) is natural and reusable by a future data-memory loader. The FSM and address counter stay in imem_loader.

Test Plan:
- Basic load: reset; start with num_words=2; stream 13 00 50 00 93 00 10 00 with byte_valid held high → writes 0x00500013 @0x00 and 0x00100093 @0x04, one imem_we each; done=1; words_written=2.
- Throttled source: byte_valid toggles 1,0,0,1,… across a 4-byte word → single write with the correct word; byte_ready never asserts in WRITE; no byte lost or duplicated.
- Full depth: num_words=0 with DEPTH=16, 64 bytes sent → 16 writes to addresses 0x00..0x3C; byte 65 is not accepted (byte_ready=0); done=1.
- Reset mid-word: after 2 bytes of word 1, pulse reset, then start with num_words=1 and send AA BB CC DD → one write of 0xDDCCBBAA @0x00.
- Start while busy: second start mid-session has no effect on the address sequence or target; the session ends after the originally latched num_words.
- Restart from DONE: after done, start with num_words=1 → done drops next cycle; the write goes to @0x00; words_written=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and word-to-byte address shift
package imem_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles four little-endian bytes into a 32-bit word
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  lane,
    output logic        word_full
);

    assign word_full = take && (lane == 2'd3);

    // Store each accepted byte in its lane; lane wraps after the fourth byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (take) begin
            word[{lane, 3'b000} +: 8] <= byte_data;
            lane                      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into instruction memory as sequential 32-bit words
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W:0]   target;
    logic [ADDR_W:0]   target_in;
    logic [1:0]        lane;
    logic              launch;
    logic              take;
    logic              word_full;

    assign launch     = start && (state == ST_IDLE || state == ST_DONE);
    assign target_in  = (num_words == '0 || num_words > FULL) ? FULL : num_words;
    assign byte_ready = (state == ST_LOAD);
    assign take       = byte_valid && byte_ready;
    assign busy       = (state == ST_LOAD) || (state == ST_WRITE);
    assign done       = (state == ST_DONE);
    assign imem_addr  = 32'(word_idx) << WORD_SHIFT;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (launch),
        .take      (take),
        .byte_data (byte_data),
        .word      (imem_wdata),
        .lane      (lane),
        .word_full (word_full)
    );

    // Session FSM with word address and completion counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            word_idx      <= '0;
            words_written <= '0;
            target        <= '0;
            imem_we       <= 1'b0;
        end else begin
            imem_we <= word_full;
            case (state)
                ST_IDLE, ST_DONE: if (start) begin
                    state         <= ST_LOAD;
                    target        <= target_in;
                    word_idx      <= '0;
                    words_written <= '0;
                end
                ST_LOAD: if (word_full) state <= ST_WRITE;
                ST_WRITE: begin
                    word_idx      <= word_idx + 1'b1;
                    words_written <= words_written + 1'b1;
                    state         <= (words_written + 1'b1 == target) ? ST_DONE : ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for the instruction-memory loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [4:0]  words_written;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    int base;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    imem_loader #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_words     (num_words),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the expected queue.
    always @(negedge clk) begin
        if (reset !== 1'b1 && imem_we === 1'b1) begin
            nwrites++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e[63:32]);
                chk("write_data", imem_wdata, e[31:0]);
            end
            chk("ready_in_write", 32'(byte_ready), 32'd0);
        end
    end

    task automatic pulse_start(input logic [4:0] n);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_words = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_wdata", imem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic two-word load with the source always valid.
        base = nwrites;
        pulse_start(5'd2);
        chk("load_busy", 32'(busy), 32'd1);
        exp_q.push_back({32'h0, 32'h00500013});
        exp_q.push_back({32'h4, 32'h00100093});
        send(8'h13, 0);
        send(8'h00, 0);
        send(8'h50, 0);
        send(8'h00, 0);
        chk("we_latency", 32'(imem_we), 32'd1);
        send_word(32'h00100093, 0);
        wait_done();
        chk("basic_words", 32'(words_written), 32'd2);
        chk("basic_writes", 32'(nwrites - base), 32'd2);
        chk("basic_busy", 32'(busy), 32'd0);

        // Throttled source: valid pattern 1,0,0,1,...
        base = nwrites;
        pulse_start(5'd1);
        exp_q.push_back({32'h0, 32'h44332211});
        send(8'h11, 0);
        send(8'h22, 2);
        send(8'h33, 2);
        send(8'h44, 2);
        wait_done();
        chk("throttle_words", 32'(words_written), 32'd1);
        chk("throttle_writes", 32'(nwrites - base), 32'd1);

        // Full depth via num_words=0.
        base = nwrites;
        pulse_start(5'd0);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] w;
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            exp_q.push_back({32'(4*k), w});
            send_word(w, 0);
        end
        wait_done();
        byte_valid = 1'b1;
        byte_data = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("full_extra_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        chk("full_words", 32'(words_written), 32'd16);
        chk("full_writes", 32'(nwrites - base), 32'd16);
        chk("full_done", 32'(done), 32'd1);

        // Reset mid-word discards the partial word.
        pulse_start(5'd1);
        send(8'h01, 0);
        send(8'h02, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("midreset");
        base = nwrites;
        pulse_start(5'd1);
        exp_q.push_back({32'h0, 32'hDDCCBBAA});
        send_word(32'hDDCCBBAA, 0);
        wait_done();
        chk("midreset_words", 32'(words_written), 32'd1);
        chk("midreset_writes", 32'(nwrites - base), 32'd1);

        // Start and reset together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        num_words = 5'd3;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk_idle("start_reset");

        // Start while busy is ignored.
        base = nwrites;
        pulse_start(5'd2);
        exp_q.push_back({32'h0, 32'h0D0C0B0A});
        exp_q.push_back({32'h4, 32'h1D1C1B1A});
        send(8'h0A, 0);
        send(8'h0B, 0);
        pulse_start(5'd5);
        send(8'h0C, 0);
        send(8'h0D, 0);
        send_word(32'h1D1C1B1A, 0);
        wait_done();
        chk("busy_start_words", 32'(words_written), 32'd2);
        chk("busy_start_writes", 32'(nwrites - base), 32'd2);

        // Restart from DONE.
        base = nwrites;
        pulse_start(5'd1);
        chk("restart_done_drop", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_words_clr", 32'(words_written), 32'd0);
        exp_q.push_back({32'h0, 32'h87654321});
        send_word(32'h87654321, 1);
        wait_done();
        chk("restart_words", 32'(words_written), 32'd1);
        chk("restart_writes", 32'(nwrites - base), 32'd1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
